imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning instruction address width (256-word store).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port load_req  input  1  level; starts a load session when sampled high in IDLE, RUN or ERR.
REQ-006 The block SHALL have port rx_valid  input  1  byte-stream valid.
REQ-007 The block SHALL have port rx_data  input  8  byte-stream data.
REQ-008 The block SHALL have port rx_ready  output  1  byte-stream ready; a byte is accepted on an edge where rx_valid && rx_ready.
REQ-009 The block SHALL have port i_addr  input  ADDR_W  CPU fetch address.
REQ-010 The block SHALL have port i_datain  output  DATA_W  fetched instruction word to the CPU.
REQ-011 The block SHALL have port cpu_enable  output  1  CPU enable.
REQ-012 The block SHALL have port cpu_start  output  1  one-cycle CPU start pulse.
REQ-013 The block SHALL have port load_busy  output  1  high in LEN, LO, HI and CHK.
REQ-014 The block SHALL have port load_err  output  1  high in ERR.

Function
REQ-015 The block SHALL implement states IDLE, LEN, LO, HI, CHK, RUN and ERR.
REQ-016 Transitions SHALL be: IDLE/RUN/ERR --load_req--> LEN; LEN --byte--> LO; LO --byte--> HI; HI --byte, words remain--> LO; HI --byte, last word--> CHK; CHK --byte, match--> RUN; CHK --byte, mismatch--> ERR.
REQ-017 load_req SHALL be ignored in LEN, LO, HI and CHK.
REQ-018 rx_ready SHALL be 1 exactly in LEN, LO, HI and CHK.
REQ-019 Byte stream framing SHALL be: length byte L (words; L=0 means 256), then per word the low byte followed by the high byte, then one checksum byte.
REQ-020 Entry to LEN SHALL clear the write pointer (8-bit) and the checksum accumulator (8-bit).
REQ-021 The word counter SHALL be 9-bit and load L, or 256 when L=0.
REQ-022 Each accepted data byte SHALL be XORed into the checksum; the length and checksum bytes SHALL NOT be.
REQ-023 On accepting a high byte, the block SHALL write {high,low} to mem[wr_ptr] on that edge, increment wr_ptr (wrapping 255->0) and decrement the word counter.
REQ-024 Locations not written in a session SHALL retain prior contents; memory is not reset.
REQ-025 i_datain SHALL be mem[i_addr] combinationally in RUN and 16'h0000 (NOP) in every other state.
REQ-026 cpu_enable SHALL be 1 exactly in RUN.
REQ-027 cpu_start SHALL be 1 only in the first cycle after entry to RUN.
REQ-028 Leaving RUN via load_req SHALL drop cpu_enable on the same edge LEN is entered.
REQ-029 Gaps in rx_valid SHALL stall the FSM with no state, pointer or checksum change.

Reset
REQ-030 While reset is high, the block SHALL be in IDLE with rx_ready, cpu_enable, cpu_start, load_busy and load_err at 0, i_datain at 0, and pointer, counter and checksum at 0, regardless of clock.
REQ-031 Reset mid-session SHALL abort the session; words already written SHALL remain in memory.

Verification
REQ-032 Load bytes 02,34,12,78,56,08 -> RUN; cpu_start high for exactly 1 cycle; i_addr=0 gives 16'h1234; i_addr=1 gives 16'h5678.
REQ-033 Same stream with checksum 09 -> ERR; load_err=1; cpu_enable=0; i_datain=0000 for any i_addr.
REQ-034 Same stream as REQ-032 with rx_valid low for 3 cycles between every pair of bytes -> identical result; byte acceptance only on handshake edges.
REQ-035 L=00 followed by 512 data bytes and the correct checksum (513 bytes after L) -> RUN; i_addr=255 returns the last word; wr_ptr wraps to 0.
REQ-036 Assert reset after 3 accepted bytes -> IDLE immediately; all outputs 0; a following full load completes correctly.
REQ-037 load_req during RUN -> cpu_enable=0 and load_busy=1 from the next edge; a new load then overwrites the words.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: loads the CPU instruction store from a framed byte stream, then serves fetches in RUN.
// Latency: one byte accepted per cycle; a word is written on the edge its high byte is accepted.
// Backpressure: rx_ready is high only in LEN/LO/HI/CHK; rx_valid gaps stall the session.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              load_busy,
  output logic              load_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LO, S_HI, S_CHK, S_RUN, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  word_cnt;
  logic [7:0]        csum;
  logic [7:0]        lo_byte;
  logic              start_q;
  logic              start_load;
  logic              accept;
  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = rx_valid && rx_ready;

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    rx_ready   = 1'b0;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_req) begin
          state_nxt  = S_LEN;
          start_load = 1'b1;
        end
      end
      S_LEN: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_LO;
      end
      S_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_HI;
      end
      S_HI: begin
        rx_ready = 1'b1;
        // word_cnt still holds the count including the word being completed
        if (rx_valid) state_nxt = (word_cnt == CNT_W'(1)) ? S_CHK : S_LO;
      end
      S_CHK: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = (rx_data == csum) ? S_RUN : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign load_busy  = rx_ready;
  assign cpu_enable = (state == S_RUN);
  assign load_err   = (state == S_ERR);
  assign cpu_start  = start_q;
  assign i_datain   = (state == S_RUN) ? mem[i_addr] : '0;

  // State register plus the one-shot start flag raised on entry to RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= (state_nxt == S_RUN) && (state != S_RUN);
    end
  end

  // Session bookkeeping: pointer, remaining-word count, checksum and pending low byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      word_cnt <= '0;
      csum     <= '0;
      lo_byte  <= '0;
    end else if (start_load) begin
      wr_ptr <= '0;
      csum   <= '0;
    end else if (accept) begin
      case (state)
        S_LEN: word_cnt <= (rx_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(rx_data);
        S_LO: begin
          lo_byte <= rx_data;
          csum    <= csum ^ rx_data;
        end
        S_HI: begin
          csum     <= csum ^ rx_data;
          wr_ptr   <= wr_ptr + 1'b1;
          word_cnt <= word_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Instruction store; deliberately not reset so a reload only touches the words it carries.
  always_ff @(posedge clock) begin
    if (accept && (state == S_HI)) mem[wr_ptr] <= DATA_W'({rx_data, lo_byte});
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: vector table, directed corner sequences and random sessions for imem_loader.
// Outputs are sampled on the falling edge; inputs change right after it.
// Expected behaviour comes from a session-level model (byte queue, word array, checksum fold).
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       load_req;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] i_addr;
  logic [15:0] i_datain;
  logic       cpu_enable;
  logic       cpu_start;
  logic       load_busy;
  logic       load_err;

  imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .load_req(load_req), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .i_addr(i_addr), .i_datain(i_datain),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start), .load_busy(load_busy),
    .load_err(load_err)
  );

  always #5 clock = ~clock;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit lr; bit v; logic [7:0] d;
    bit rdy; bit busy; bit err; bit en; bit st;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: observable mode (0 idle, 1 loading, 2 run, 3 error), session bytes, store image.
  int          mode = 0;
  bit          first = 1'b0;
  logic [7:0]  sess[$];
  logic [15:0] mm [256];
  bit          wr [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("rx_ready", 32'(rx_ready), 32'(mode == 1));
    chk("load_busy", 32'(load_busy), 32'(mode == 1));
    chk("load_err", 32'(load_err), 32'(mode == 3));
    chk("cpu_enable", 32'(cpu_enable), 32'(mode == 2));
    chk("cpu_start", 32'(cpu_start), 32'(mode == 2 && first));
    if (mode != 2) chk("i_datain_nop", 32'(i_datain), 32'h0);
    else if (wr[i_addr]) chk("i_datain_run", 32'(i_datain), 32'(mm[i_addr]));
  endtask

  task automatic check_zero();
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_load_busy", 32'(load_busy), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);
    chk("rst_cpu_enable", 32'(cpu_enable), 32'h0);
    chk("rst_cpu_start", 32'(cpu_start), 32'h0);
    chk("rst_i_datain", 32'(i_datain), 32'h0);
  endtask

  // One clock: drive inputs, advance the model by the framing rules, check after the edge.
  task automatic cycle(input bit lr, input bit v, input logic [7:0] d);
    int n;
    int sz;
    logic [7:0] x;
    load_req = lr;
    rx_valid = v;
    rx_data  = d;
    i_addr   = 8'($urandom_range(0, 255));
    first    = 1'b0;
    if (mode != 1 && lr) begin
      mode = 1;
      sess.delete();
    end else if (mode == 1 && v) begin
      sess.push_back(d);
      sz = sess.size();
      n  = (sess[0] == 8'd0) ? 256 : int'(sess[0]);
      if (sz >= 3 && (sz % 2) == 1 && sz <= 2 * n + 1) begin
        mm[((sz - 3) / 2) % 256] = {d, sess[sz - 2]};
        wr[((sz - 3) / 2) % 256] = 1'b1;
      end
      if (sz == 2 * n + 2) begin
        x = 8'h00;
        for (int i = 1; i <= 2 * n; i++) x = x ^ sess[i];
        mode  = (x == d) ? 2 : 3;
        first = (mode == 2);
      end
    end
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  // Start a session and feed bytes; gap < 0 picks 0..2 idle cycles per byte.
  task automatic send(input bq_t b, input int gap, input bit noise);
    int g;
    cycle(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < b.size(); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++)
        cycle(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 8'($urandom));
      cycle(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, b[i]);
    end
  endtask

  function automatic bq_t make_stream(input int nw, input bit bad);
    bq_t q;
    logic [7:0] x;
    logic [7:0] bb;
    x = 8'h00;
    q.push_back(8'(nw));
    for (int i = 0; i < 2 * nw; i++) begin
      bb = 8'($urandom);
      q.push_back(bb);
      x = x ^ bb;
    end
    q.push_back(bad ? ~x : x);
    return q;
  endfunction

  task automatic probe(input string nm, input logic [7:0] a, input logic [15:0] exp);
    i_addr = a;
    #1;
    chk(nm, 32'(i_datain), 32'(exp));
  endtask

  vec_t tbl[11];
  bq_t  s;

  initial begin
    reset = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; i_addr = 8'h00;
    for (int i = 0; i < 256; i++) wr[i] = 1'b0;
    #3;
    check_zero();
    load_req = 1'b1; rx_valid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_zero();
    @(negedge clock);
    load_req = 1'b0; rx_valid = 1'b0;
    reset = 1'b0;

    //           lr  v   data   rdy busy err en st
    tbl[0]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h78, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h56, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].lr, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_rdy", i), 32'(rx_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i), 32'(load_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_err", i), 32'(load_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_en", i), 32'(cpu_enable), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_st", i), 32'(cpu_start), 32'(tbl[i].st));
      if (i == 9) begin
        probe("run_addr0", 8'd0, 16'h1234);
        probe("run_addr1", 8'd1, 16'h5678);
      end
    end

    // Reload from RUN overwrites both words.
    cycle(1'b0, 1'b1, 8'h02);
    cycle(1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b1, 8'h22);
    cycle(1'b0, 1'b1, 8'h33);
    cycle(1'b0, 1'b1, 8'h44);
    cycle(1'b0, 1'b1, 8'h44);
    probe("reload_addr0", 8'd0, 16'h2211);
    probe("reload_addr1", 8'd1, 16'h4433);

    // Bad checksum lands in ERR with NOP fetches.
    s = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09};
    send(s, 0, 1'b0);
    chk("err_load_err", 32'(load_err), 32'h1);
    chk("err_cpu_enable", 32'(cpu_enable), 32'h0);
    probe("err_nop0", 8'd0, 16'h0000);
    probe("err_nop1", 8'd1, 16'h0000);
    probe("err_nop80", 8'h80, 16'h0000);

    // Three idle cycles between every byte gives the same result.
    s = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08};
    send(s, 3, 1'b1);
    chk("gap_cpu_enable", 32'(cpu_enable), 32'h1);
    probe("gap_addr0", 8'd0, 16'h1234);
    probe("gap_addr1", 8'd1, 16'h5678);
    cycle(1'b0, 1'b0, 8'h00);

    // Length byte zero means 256 words.
    s = make_stream(256, 1'b0);
    send(s, 0, 1'b0);
    chk("full_cpu_enable", 32'(cpu_enable), 32'h1);
    probe("full_addr255", 8'd255, {s[512], s[511]});
    probe("full_addr0", 8'd0, {s[2], s[1]});

    // Reset after three accepted bytes aborts but keeps the written word.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h02);
    cycle(1'b0, 1'b1, 8'h34);
    cycle(1'b0, 1'b1, 8'h12);
    #2 reset = 1'b1;
    #1;
    check_zero();
    mode = 0; first = 1'b0; sess.delete();
    load_req = 1'b0; rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    s = '{8'h01, 8'hCD, 8'hAB, 8'h66};
    send(s, 0, 1'b0);
    chk("postrst_cpu_enable", 32'(cpu_enable), 32'h1);
    probe("postrst_addr0", 8'd0, 16'hABCD);

    // Random sessions: lengths, gaps, ignored load_req noise, occasional bad checksum.
    for (int r = 0; r < 12; r++) begin
      s = make_stream(int'($urandom_range(1, 24)), $urandom_range(0, 3) == 0);
      send(s, -1, 1'b1);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
